// File: rtl/operand_entry.sv
// operand_entry
//   Turns debounced pushbuttons and slider switches into edits of a shadow
//   operand. When the operand is committed it is offered downstream over a
//   valid/ready handshake.
//
//   The center button shifts the switch byte in from the bottom. Up and down
//   add or subtract one, and auto-repeat while they are held. Left clears
//   the shadow. Right commits the shadow to the consumer.
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   pbtn_db[4:0] debounced buttons {right, left, down, up, center}
//   swtch_db     debounced switch byte
//   pb_pulse     registered one-cycle event per button, repeats included
//   operand      committed operand (valid while op_valid)
//   op_valid     operand offered to consumer
//   op_ready     consumer accepts operand
//   shadow       value being edited
//   byte_cnt     bytes shifted in since last clear/commit, saturating

// Auto-repeat timer for one button.
// cnt tracks how many edges the button has been held since its press.
// A button already held when reset is released leaves cnt at 0, so it
// never starts repeating until it is released and pressed again.
module operand_entry_rpt #(
    parameter int DLY  = 8,
    parameter int RATE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic held,    // button level this cycle
    input  logic press,   // rising edge this cycle
    input  logic others,  // some other button is also held
    output logic fire     // repeat event for this edge
);
    localparam int CNT_W = $clog2(DLY + RATE + 1);
    localparam logic [CNT_W-1:0] C_DLY  = CNT_W'(DLY);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DLY + RATE);
    localparam logic [CNT_W-1:0] C_LOOP = CNT_W'(DLY + 1);

    logic [CNT_W-1:0] cnt;

    // Held count n fires at n == DLY, then again every RATE edges after that.
    // Once n passes DLY, cnt cycles through DLY+1 .. DLY+RATE.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (!held)
            cnt <= '0;
        else if (press || cnt != '0)
            cnt <= (cnt == C_LAST) ? C_LOOP : cnt + CNT_W'(1);
    end

    // The timer keeps running while another button is held.
    // Only the event itself is masked.
    assign fire = held && !others && (cnt == C_DLY || cnt == C_LAST);
endmodule

module operand_entry #(
    parameter int OP_WIDTH    = 32,
    parameter bit simulate    = 1'b0,
    parameter int REPEAT_DLY  = simulate ? 8 : 50_000_000,
    parameter int REPEAT_RATE = simulate ? 3 : 10_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          pbtn_db,
    input  logic [7:0]          swtch_db,
    output logic [4:0]          pb_pulse,
    output logic [OP_WIDTH-1:0] operand,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [OP_WIDTH-1:0] shadow,
    output logic [2:0]          byte_cnt
);
    localparam int B_CTR = 0, B_UP = 1, B_DN = 2, B_LFT = 3, B_RGT = 4;
    localparam logic [2:0] MAX_BYTES = 3'(OP_WIDTH / 8);

    typedef enum logic {EDIT, HOLD} state_t;
    state_t state;

    logic [4:0] prev;
    logic [4:0] rise;
    logic [2:1] rep;
    logic [4:0] pulse_nxt;

    assign rise = pbtn_db & ~prev;

    // Only up and down get auto-repeat.
    for (genvar gi = 1; gi <= 2; gi++) begin : g_rpt
        operand_entry_rpt #(
            .DLY  (REPEAT_DLY),
            .RATE (REPEAT_RATE)
        ) u_rpt (
            .clk    (clk),
            .reset  (reset),
            .held   (pbtn_db[gi]),
            .press  (rise[gi]),
            .others (|(pbtn_db & ~(5'b00001 << gi))),
            .fire   (rep[gi])
        );
    end

    assign pulse_nxt = rise | {2'b00, rep, 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            // prev loads all ones, so a button held through reset is not
            // seen as a fresh press.
            prev     <= 5'h1F;
            pb_pulse <= '0;
            operand  <= '0;
            op_valid <= 1'b0;
            shadow   <= '0;
            byte_cnt <= '0;
            state    <= EDIT;
        end else begin
            prev     <= pbtn_db;
            pb_pulse <= pulse_nxt;
            case (state)
                EDIT: begin
                    // One action per edge: left > right > center > up > down.
                    if (pb_pulse[B_LFT]) begin
                        shadow   <= '0;
                        byte_cnt <= '0;
                    end else if (pb_pulse[B_RGT]) begin
                        operand  <= shadow;
                        op_valid <= 1'b1;
                        shadow   <= '0;
                        byte_cnt <= '0;
                        state    <= HOLD;
                    end else if (pb_pulse[B_CTR]) begin
                        shadow <= {shadow[OP_WIDTH-9:0], swtch_db};
                        if (byte_cnt != MAX_BYTES)
                            byte_cnt <= byte_cnt + 3'd1;
                    end else if (pb_pulse[B_UP]) begin
                        shadow <= shadow + OP_WIDTH'(1);
                    end else if (pb_pulse[B_DN]) begin
                        shadow <= shadow - OP_WIDTH'(1);
                    end
                end
                HOLD: begin
                    // Button events are dropped here.
                    // pb_pulse still reports them.
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= EDIT;
                    end
                end
                default: state <= EDIT;
            endcase
        end
    end
endmodule
